lfsr_checker: RTL and testbench

Receive-side companion to the 8-bit XNOR LFSR random number generator. It consumes the generator's word stream, self-synchronises to it, and then verifies every subsequent word against its own free-running prediction. It reports lock status, per-word error pulses and a saturating error count. It sits downstream of the generator, or at the far end of any link carrying its output, for self-test and link-integrity checking.

---
 rtl/lfsr_checker_if.sv | 24 ++
 rtl/lfsr_checker.sv | 156 +++++++++++++++
 tb/tb_lfsr_checker.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_checker_if.sv
// Word-stream bus between an 8-bit XNOR LFSR source and lfsr_checker:
// the source drives clear/valid/data and the checker returns its status.
interface lfsr_checker_if #(
  parameter int CNT_W = 16
);
  logic             clear;
  logic             valid;
  logic [7:0]       data;
  logic             locked;
  logic             err;
  logic             lockup;
  logic [CNT_W-1:0] err_count;
  logic [7:0]       expected;

  modport master (
    output clear, valid, data,
    input  locked, err, lockup, err_count, expected
  );

  modport slave (
    input  clear, valid, data,
    output locked, err, lockup, err_count, expected
  );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 8-bit XNOR LFSR stream: HUNT -> SYNC -> LOCKED flywheel,
// registered err/lockup pulses and a saturating error count. `define LFSR_CHECKER_LOSS_EN to drop lock after LOSS_CNT misses.
module lfsr_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  lfsr_checker_if.slave bus
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  if (LOCK_CNT < 1 || LOCK_CNT > 15 || LOSS_CNT < 1 || LOSS_CNT > 15) begin : g_bad_param
    $error("lfsr_checker: LOCK_CNT and LOSS_CNT must lie in 1..15");
  end

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[6:0], ~(x[2] ^ x[3] ^ x[4] ^ x[6])};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [7:0]       ref_q, ref_d;
  logic [3:0]       sync_cnt_q, sync_cnt_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             lockup_q, lockup_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
`ifdef LFSR_CHECKER_LOSS_EN
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);
  logic [3:0]       miss_cnt_q, miss_cnt_d;
`endif

  logic [7:0] pred;
  logic       hit;
  logic       is_ff;

  always_comb begin
    pred        = nxt(ref_q);
    hit         = (bus.data == pred);
    is_ff       = (bus.data == 8'hFF);
    state_d     = state_q;
    ref_d       = ref_q;
    sync_cnt_d  = sync_cnt_q;
    err_count_d = err_count_q;
    err_d       = 1'b0;
    lockup_d    = 1'b0;
`ifdef LFSR_CHECKER_LOSS_EN
    miss_cnt_d  = miss_cnt_q;
`endif

    if (bus.clear) begin
      state_d     = ST_HUNT;
      sync_cnt_d  = '0;
      err_count_d = '0;
`ifdef LFSR_CHECKER_LOSS_EN
      miss_cnt_d  = '0;
`endif
    end else if (bus.valid) begin
      case (state_q)
        ST_HUNT: begin
          // All-ones is the XNOR fixed point and can never seed a sequence.
          if (is_ff) begin
            lockup_d = 1'b1;
          end else begin
            ref_d      = bus.data;
            sync_cnt_d = '0;
            state_d    = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (hit) begin
            ref_d      = bus.data;
            sync_cnt_d = sync_cnt_q + 4'd1;
            if (sync_cnt_q + 4'd1 == LOCK_TGT) begin
              state_d = ST_LOCKED;
`ifdef LFSR_CHECKER_LOSS_EN
              miss_cnt_d = '0;
`endif
            end
          end else if (is_ff) begin
            lockup_d = 1'b1;
            state_d  = ST_HUNT;
          end else begin
            ref_d      = bus.data;
            sync_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: the prediction advances on its own so a corrupt word cannot derail it.
          ref_d = pred;
          if (hit) begin
`ifdef LFSR_CHECKER_LOSS_EN
            miss_cnt_d = '0;
`endif
          end else begin
            err_d = 1'b1;
            if (err_count_q != {CNT_W{1'b1}}) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
`ifdef LFSR_CHECKER_LOSS_EN
            if (miss_cnt_q + 4'd1 == LOSS_TGT) begin
              state_d    = ST_HUNT;
              sync_cnt_d = '0;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 4'd1;
            end
`endif
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      ref_q       <= 8'h00;
      sync_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      lockup_q    <= 1'b0;
      err_count_q <= '0;
`ifdef LFSR_CHECKER_LOSS_EN
      miss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      sync_cnt_q  <= sync_cnt_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      lockup_q    <= lockup_d;
      err_count_q <= err_count_d;
`ifdef LFSR_CHECKER_LOSS_EN
      miss_cnt_q  <= miss_cnt_d;
`endif
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.lockup    = lockup_q;
  assign bus.err_count = err_count_q;
  assign bus.expected  = ref_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a 16-bit and a 4-bit counter instance share one stimulus stream,
// a reference model queues the expected registered outputs and a monitor compares them each cycle.
module tb_lfsr_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;
`ifdef LFSR_CHECKER_LOSS_EN
  localparam logic        LOSS_LOCKED_WANT = 1'b0;
  localparam logic [3:0]  SAT4_WANT        = 4'd3;
  localparam logic [15:0] SAT16_WANT       = 16'd3;
`else
  localparam logic        LOSS_LOCKED_WANT = 1'b1;
  localparam logic [3:0]  SAT4_WANT        = 4'hF;
  localparam logic [15:0] SAT16_WANT       = 16'd20;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr_checker_if #(.CNT_W(16)) bus16 ();
  lfsr_checker_if #(.CNT_W(4))  bus4 ();

  assign bus4.clear = bus16.clear;
  assign bus4.valid = bus16.valid;
  assign bus4.data  = bus16.data;

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  typedef struct packed {
    logic        locked;
    logic        err;
    logic        lockup;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;
    logic [7:0]  expected;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: phase 0 = hunting, 1 = confirming, 2 = locked.
  int         m_phase;
  logic [7:0] m_ref;
  int         m_run;
  int         m_miss;
  int         m_errs;
  bit         m_err;
  bit         m_lockup;

  // Successor: shift left, new LSB is 1 when taps 2,3,4,6 hold an even number of ones.
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    logic [7:0] s;
    s = x << 1;
    if (($countones(x & 8'h5C) % 2) == 0) s = s | 8'h01;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, got, want);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ref = 8'h00; m_run = 0; m_miss = 0; m_errs = 0;
    m_err = 0; m_lockup = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit c);
    logic [7:0] p;
    p        = lfsr_next(m_ref);
    m_err    = 0;
    m_lockup = 0;
    if (c) begin
      m_phase = 0; m_run = 0; m_miss = 0; m_errs = 0;
    end else if (v) begin
      if (m_phase == 0) begin
        if (d == 8'hFF) m_lockup = 1;
        else begin m_ref = d; m_run = 0; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (d == p) begin
          m_ref = d;
          m_run++;
          if (m_run == LOCK_CNT) begin m_phase = 2; m_miss = 0; end
        end else if (d == 8'hFF) begin
          m_lockup = 1; m_phase = 0;
        end else begin
          m_ref = d; m_run = 0;
        end
      end else begin
        m_ref = p;
        if (d == p) m_miss = 0;
        else begin
          m_err = 1;
          m_errs++;
          m_miss++;
`ifdef LFSR_CHECKER_LOSS_EN
          if (m_miss == LOSS_CNT) begin m_phase = 0; m_run = 0; m_miss = 0; end
`endif
        end
      end
    end
  endtask

  function automatic exp_t mk_exp();
    exp_t e;
    e.locked   = (m_phase == 2);
    e.err      = m_err;
    e.lockup   = m_lockup;
    e.cnt16    = (m_errs > 65535) ? 16'hFFFF : 16'(m_errs);
    e.cnt4     = (m_errs > 15) ? 4'hF : 4'(m_errs);
    e.expected = m_ref;
    return e;
  endfunction

  task automatic step(input bit v, input logic [7:0] d, input bit c);
    @(negedge clk);
    bus16.valid = v;
    bus16.data  = d;
    bus16.clear = c;
    model_step(v, d, c);
    exp_q.push_back(mk_exp());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic acquire();
    step(1, 8'h01, 0); step(1, 8'h03, 0); step(1, 8'h07, 0);
    step(1, 8'h0E, 0); step(1, 8'h1D, 0);
  endtask

  function automatic logic [31:0] outs();
    exp_t a;
    a = {bus16.locked, bus16.err, bus16.lockup, bus16.err_count, bus4.err_count, bus16.expected};
    return 32'(a);
  endfunction

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    bus16.valid = 1'b0;
    bus16.clear = 1'b0;
    model_reset();
    #1;
    check(name, outs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every cycle the registered outputs are the DUT's response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", outs(), 32'(e));
      end
    end
  end

  initial begin
    logic [7:0] s;
    logic [7:0] g;
    int         r;

    rst = 1'b1;
    bus16.valid = 1'b0;
    bus16.data  = 8'h00;
    bus16.clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", outs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    acquire();
    settle();
    check("acq_locked", 32'(bus16.locked), 32'd1);
    check("acq_no_err", 32'(bus16.err_count), 32'd0);

    step(1, 8'h3A, 0);
    step(1, 8'h00, 0);
    settle();
    check("fly_err", {bus16.err, bus16.locked, bus16.err_count}, {1'b1, 1'b1, 16'd1});
    check("fly_pred", 32'(bus16.expected), 32'h75);
    step(1, 8'hEA, 0);
    settle();
    check("fly_resync", {bus16.err, bus16.locked, bus16.expected}, {1'b0, 1'b1, 8'hEA});

    step(1, 8'h00, 1);
    acquire();
    repeat (3) step(1, 8'h00, 0);
    settle();
    check("loss_cnt", 32'(bus16.err_count), 32'd3);
    check("loss_locked", 32'(bus16.locked), 32'(LOSS_LOCKED_WANT));

    step(1, 8'h00, 1);
    acquire();
    repeat (20) step(1, 8'h00, 0);
    settle();
    check("sat_cnt4", 32'(bus4.err_count), 32'(SAT4_WANT));
    check("sat_cnt16", 32'(bus16.err_count), 32'(SAT16_WANT));

    step(1, 8'h01, 1);
    settle();
    check("clear_cnt", {bus16.locked, bus16.err_count, bus4.err_count}, 32'd0);
    step(1, 8'h03, 0); step(1, 8'h07, 0); step(1, 8'h0E, 0); step(1, 8'h1D, 0);
    settle();
    check("clear_discard", 32'(bus16.locked), 32'd0);
    step(1, 8'h3A, 0);
    settle();
    check("clear_relock", 32'(bus16.locked), 32'd1);

    step(1, 8'h00, 1);
    step(1, 8'hFF, 0);
    settle();
    check("hunt_lockup", {bus16.lockup, bus16.locked}, {1'b1, 1'b0});
    step(1, 8'h01, 0); step(1, 8'h03, 0); step(1, 8'hFF, 0);
    settle();
    check("sync_lockup", {bus16.lockup, bus16.locked}, {1'b1, 1'b0});

    step(1, 8'h01, 0); step(1, 8'h03, 0); step(1, 8'h55, 0);
    s = 8'h55;
    for (int i = 0; i < LOCK_CNT - 1; i++) begin
      s = lfsr_next(s);
      step(1, s, 0);
    end
    settle();
    check("reseed_pending", 32'(bus16.locked), 32'd0);
    s = lfsr_next(s);
    step(1, s, 0);
    settle();
    check("reseed_locked", {bus16.locked, bus16.err}, {1'b1, 1'b0});

    step(1, 8'h00, 1);
    step(1, 8'h01, 0); step(1, 8'h03, 0);
    step(0, 8'h00, 0);
    do_reset("rst_mid_sync");

    g = 8'h01;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (g == 8'hFF) g = 8'($urandom_range(0, 254));
      if (r < 15) begin
        step(0, 8'($urandom), 0);
      end else if (r < 17) begin
        step(1, 8'($urandom), 1);
      end else if (r < 19) begin
        step(1, 8'hFF, 0);
      end else if (r < 25) begin
        step(1, g ^ (8'h01 << $urandom_range(0, 7)), 0);
        g = lfsr_next(g);
      end else if (r < 26) begin
        g = 8'($urandom_range(0, 254));
        step(1, g, 0);
        g = lfsr_next(g);
      end else begin
        step(1, g, 0);
        g = lfsr_next(g);
      end
      if (i == 1500) do_reset("rst_random");
    end

    @(negedge clk);
    bus16.valid = 1'b0;
    bus16.clear = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
